// File: rtl/mine_probe_if.sv
// ============================================================================
//  Module   : mine_probe_if
//  Purpose  : Click request / cell result bundle between the cell-index logic
//             and the Saper cell-action engine.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface mine_probe_if #(
    parameter int IDX_W = 5
);
    logic             req_valid;
    logic             req_ready;
    logic             req_flag;
    logic [IDX_W-1:0] req_x;
    logic [IDX_W-1:0] req_y;

    logic             res_valid;
    logic [IDX_W-1:0] res_x;
    logic [IDX_W-1:0] res_y;
    logic             res_explode;
    logic             res_reveal;
    logic             res_flagged;
    logic             res_ignored;
    logic [3:0]       res_count;

    modport master (
        output req_valid, req_flag, req_x, req_y,
        input  req_ready,
        input  res_valid, res_x, res_y, res_explode, res_reveal,
               res_flagged, res_ignored, res_count
    );

    modport slave (
        input  req_valid, req_flag, req_x, req_y,
        output req_ready,
        output res_valid, res_x, res_y, res_explode, res_reveal,
               res_flagged, res_ignored, res_count
    );
endinterface

`default_nettype wire

// File: rtl/mine_probe.sv
// ============================================================================
//  Module   : mine_probe
//  Purpose  : Saper cell-action engine: flag toggle, reveal with mine-hit
//             detection and sequential 8-neighbour adjacent-mine count.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module mine_probe #(
    parameter int MAX_DIM = 16,
    parameter int IDX_W   = 5,
    parameter int FCNT_W  = 9
) (
    input  wire logic                         clk,
    input  wire logic                         rst,
    input  wire logic                         clear,
    input  wire logic [IDX_W-1:0]             board_dim,
    input  wire logic [MAX_DIM*MAX_DIM-1:0]   mine_map,
    mine_probe_if.slave                       bus,
    output logic      [FCNT_W-1:0]            flags_used,
    output logic                              game_over
);
    localparam int c_cells = MAX_DIM * MAX_DIM;
    localparam int c_aw    = $clog2(c_cells);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_check = 2'd1;
    localparam logic [1:0] c_st_scan  = 2'd2;
    localparam logic [1:0] c_st_done  = 2'd3;

    localparam logic [IDX_W-1:0]  c_idx_one  = IDX_W'(1);
    localparam logic [FCNT_W-1:0] c_fcnt_one = FCNT_W'(1);

    logic [1:0]         r_state, w_state_nxt;
    logic [IDX_W-1:0]   r_x, r_y, r_dim;
    logic               r_flag;
    logic [2:0]         r_scan_idx, w_scan_idx_nxt;
    logic [3:0]         r_acc, w_acc_nxt;
    logic [c_cells-1:0] r_flags, r_revealed;
    logic [FCNT_W-1:0]  r_flags_used;
    logic               r_game_over;

    logic               r_res_valid, r_res_explode, r_res_reveal, r_res_flagged, r_res_ignored;
    logic [3:0]         r_res_count;
    logic               w_res_valid, w_res_explode, w_res_reveal, w_res_flagged, w_res_ignored;
    logic [3:0]         w_res_count;

    logic               w_accept;
    logic [c_aw-1:0]    w_cell, w_nidx;
    logic               w_dx_neg, w_dx_pos, w_dy_neg, w_dy_pos;
    logic [IDX_W-1:0]   w_nx, w_ny;
    logic               w_n_ok, w_hit, w_oob;
    logic [3:0]         w_sum;

    assign w_accept = bus.req_valid && (r_state == c_st_idle);
    assign w_cell   = c_aw'(r_y) * c_aw'(MAX_DIM) + c_aw'(r_x);

    // Neighbour order: row above left-to-right, same row left/right, row below.
    always_comb begin
        w_dx_neg = 1'b0;
        w_dx_pos = 1'b0;
        w_dy_neg = 1'b0;
        w_dy_pos = 1'b0;
        case (r_scan_idx)
            3'd0: begin w_dy_neg = 1'b1; w_dx_neg = 1'b1; end
            3'd1: begin w_dy_neg = 1'b1; end
            3'd2: begin w_dy_neg = 1'b1; w_dx_pos = 1'b1; end
            3'd3: begin w_dx_neg = 1'b1; end
            3'd4: begin w_dx_pos = 1'b1; end
            3'd5: begin w_dy_pos = 1'b1; w_dx_neg = 1'b1; end
            3'd6: begin w_dy_pos = 1'b1; end
            default: begin w_dy_pos = 1'b1; w_dx_pos = 1'b1; end
        endcase
    end

    assign w_nx   = w_dx_neg ? (r_x - c_idx_one) : (w_dx_pos ? (r_x + c_idx_one) : r_x);
    assign w_ny   = w_dy_neg ? (r_y - c_idx_one) : (w_dy_pos ? (r_y + c_idx_one) : r_y);
    // Underflow at column/row 0 is rejected explicitly; overflow by the dim compare.
    assign w_n_ok = !(w_dx_neg && (r_x == '0)) && !(w_dy_neg && (r_y == '0)) &&
                    (w_nx < r_dim) && (w_ny < r_dim);
    assign w_nidx = c_aw'(w_ny) * c_aw'(MAX_DIM) + c_aw'(w_nx);
    assign w_hit  = w_n_ok && mine_map[w_nidx];
    assign w_sum  = r_acc + {3'b000, w_hit};
    assign w_oob  = r_game_over || (r_x >= r_dim) || (r_y >= r_dim);

    always_comb begin
        w_state_nxt    = r_state;
        w_scan_idx_nxt = r_scan_idx;
        w_acc_nxt      = r_acc;
        w_res_valid    = 1'b0;
        w_res_explode  = 1'b0;
        w_res_reveal   = 1'b0;
        w_res_flagged  = 1'b0;
        w_res_ignored  = 1'b0;
        w_res_count    = 4'd0;
        case (r_state)
            c_st_idle: begin
                if (w_accept) w_state_nxt = c_st_check;
            end
            c_st_check: begin
                w_state_nxt = c_st_done;
                w_res_valid = 1'b1;
                if (w_oob) begin
                    w_res_ignored = 1'b1;
                end else if (r_flag && r_revealed[w_cell]) begin
                    w_res_ignored = 1'b1;
                end else if (r_flag) begin
                    w_res_flagged = !r_flags[w_cell];
                end else if (r_flags[w_cell] || r_revealed[w_cell]) begin
                    w_res_ignored = 1'b1;
                end else if (mine_map[w_cell]) begin
                    w_res_explode = 1'b1;
                end else begin
                    w_state_nxt    = c_st_scan;
                    w_res_valid    = 1'b0;
                    w_scan_idx_nxt = 3'd0;
                    w_acc_nxt      = 4'd0;
                end
            end
            c_st_scan: begin
                w_acc_nxt      = w_sum;
                w_scan_idx_nxt = r_scan_idx + 3'd1;
                if (r_scan_idx == 3'd7) begin
                    w_state_nxt  = c_st_done;
                    w_res_valid  = 1'b1;
                    w_res_reveal = 1'b1;
                    w_res_count  = w_sum;
                end
            end
            default: begin
                w_state_nxt = c_st_idle;
            end
        endcase
        if (clear) begin
            w_state_nxt   = c_st_idle;
            w_res_valid   = 1'b0;
            w_res_explode = 1'b0;
            w_res_reveal  = 1'b0;
            w_res_flagged = 1'b0;
            w_res_ignored = 1'b0;
            w_res_count   = 4'd0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= c_st_idle;
            r_x           <= '0;
            r_y           <= '0;
            r_dim         <= '0;
            r_flag        <= 1'b0;
            r_scan_idx    <= 3'd0;
            r_acc         <= 4'd0;
            r_flags       <= '0;
            r_revealed    <= '0;
            r_flags_used  <= '0;
            r_game_over   <= 1'b0;
            r_res_valid   <= 1'b0;
            r_res_explode <= 1'b0;
            r_res_reveal  <= 1'b0;
            r_res_flagged <= 1'b0;
            r_res_ignored <= 1'b0;
            r_res_count   <= 4'd0;
        end else begin
            r_state       <= w_state_nxt;
            r_scan_idx    <= w_scan_idx_nxt;
            r_acc         <= w_acc_nxt;
            r_res_valid   <= w_res_valid;
            r_res_explode <= w_res_explode;
            r_res_reveal  <= w_res_reveal;
            r_res_flagged <= w_res_flagged;
            r_res_ignored <= w_res_ignored;
            r_res_count   <= w_res_count;
            if (w_accept && !clear) begin
                r_x    <= bus.req_x;
                r_y    <= bus.req_y;
                r_flag <= bus.req_flag;
                r_dim  <= board_dim;
            end
            // Board state commits on leaving DONE so a clear in DONE discards it.
            if (clear) begin
                r_flags      <= '0;
                r_revealed   <= '0;
                r_flags_used <= '0;
                r_game_over  <= 1'b0;
            end else if (r_state == c_st_done) begin
                if (r_res_reveal || r_res_explode) r_revealed[w_cell] <= 1'b1;
                if (r_flag && !r_res_ignored) begin
                    r_flags[w_cell] <= r_res_flagged;
                    r_flags_used    <= r_res_flagged ? (r_flags_used + c_fcnt_one)
                                                     : (r_flags_used - c_fcnt_one);
                end
                if (r_res_explode) r_game_over <= 1'b1;
            end
        end
    end

    assign bus.req_ready   = (r_state == c_st_idle);
    assign bus.res_valid   = r_res_valid;
    assign bus.res_x       = r_x;
    assign bus.res_y       = r_y;
    assign bus.res_explode = r_res_explode;
    assign bus.res_reveal  = r_res_reveal;
    assign bus.res_flagged = r_res_flagged;
    assign bus.res_ignored = r_res_ignored;
    assign bus.res_count   = r_res_count;
    assign flags_used      = r_flags_used;
    assign game_over       = r_game_over;
endmodule

`default_nettype wire

// File: tb/tb_mine_probe.sv
// ============================================================================
//  Module   : tb_mine_probe
//  Purpose  : Directed-vector scoreboard bench for the mine_probe engine.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mine_probe;
    localparam int MD = 16;
    localparam int IW = 5;
    localparam int FW = 9;

    localparam int F_IGN = 1;
    localparam int F_FLG = 2;
    localparam int F_REV = 4;
    localparam int F_EXP = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              clear;
    logic [IW-1:0]     board_dim;
    logic [MD*MD-1:0]  mine_map;
    logic [FW-1:0]     flags_used;
    logic              game_over;

    mine_probe_if #(.IDX_W(IW)) bus ();

    mine_probe #(.MAX_DIM(MD), .IDX_W(IW), .FCNT_W(FW)) dut (
        .clk        (clk),
        .rst        (rst),
        .clear      (clear),
        .board_dim  (board_dim),
        .mine_map   (mine_map),
        .bus        (bus),
        .flags_used (flags_used),
        .game_over  (game_over)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int x;
        int y;
        int flags;
        int count;
        int acc_edge;
        int lat;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    // Monitor: pops one expectation per result pulse.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && bus.res_valid) begin
                if (q.size() == 0) begin
                    chk("unexpected_res_valid", 1, 0);
                end else begin
                    e = q.pop_front();
                    chk("res_xy", int'(bus.res_x) * 100 + int'(bus.res_y), e.x * 100 + e.y);
                    chk("res_flags", int'({bus.res_explode, bus.res_reveal,
                                           bus.res_flagged, bus.res_ignored}), e.flags);
                    chk("res_count", int'(bus.res_count), e.count);
                    // Result is captured by the edge after this negedge.
                    chk("res_latency", cyc + 1 - e.acc_edge, e.lat);
                end
            end
        end
    end

    task automatic click(input bit flag, input int x, input int y, input bit track,
                         input int fl, input int cnt, input int lat);
        exp_t e;
        int   n;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_flag  = flag;
        bus.req_x     = IW'(x);
        bus.req_y     = IW'(y);
        n = 0;
        while (!bus.req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!bus.req_ready) begin
            chk("req_ready_timeout", 0, 1);
            bus.req_valid = 1'b0;
        end else begin
            if (track) begin
                e.x = x; e.y = y; e.flags = fl; e.count = cnt;
                e.acc_edge = cyc + 1; e.lat = lat;
                q.push_back(e);
            end
            @(negedge clk);
            bus.req_valid = 1'b0;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (q.size() != 0) begin
            chk("result_timeout", q.size(), 0);
            q.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic new_game(input int dim, input logic [MD*MD-1:0] map);
        @(negedge clk);
        clear     = 1'b1;
        board_dim = IW'(dim);
        mine_map  = map;
        @(negedge clk);
        clear = 1'b0;
    endtask

    function automatic logic [MD*MD-1:0] mine_at(input logic [MD*MD-1:0] m, input int x, input int y);
        logic [MD*MD-1:0] r;
        r = m;
        r[y * MD + x] = 1'b1;
        return r;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [MD*MD-1:0] m;
        rst           = 1'b1;
        clear         = 1'b0;
        board_dim     = IW'(8);
        mine_map      = '0;
        bus.req_valid = 1'b0;
        bus.req_flag  = 1'b0;
        bus.req_x     = '0;
        bus.req_y     = '0;
        repeat (3) @(negedge clk);
        chk("reset_req_ready", int'(bus.req_ready), 1);
        chk("reset_res_valid", int'(bus.res_valid), 0);
        chk("reset_res_bits", int'({bus.res_explode, bus.res_reveal, bus.res_flagged,
                                    bus.res_ignored, bus.res_count}), 0);
        chk("reset_flags_used", int'(flags_used), 0);
        chk("reset_game_over", int'(game_over), 0);
        rst = 1'b0;

        // T1: empty 8x8 board, corner reveal
        new_game(8, '0);
        click(0, 0, 0, 1, F_REV, 0, 10);
        drain();

        // T2: three mines around the corner, then repeat/flag on revealed cell
        m = '0; m = mine_at(m, 1, 0); m = mine_at(m, 0, 1); m = mine_at(m, 1, 1);
        new_game(8, m);
        click(0, 0, 0, 1, F_REV, 3, 10);
        drain();
        click(0, 0, 0, 1, F_IGN, 0, 2);
        click(1, 0, 0, 1, F_IGN, 0, 2);
        drain();
        chk("t2_flags_used", int'(flags_used), 0);

        // Fully surrounded cell: count saturates at 8
        m = '0;
        for (int dy = -1; dy <= 1; dy++)
            for (int dx = -1; dx <= 1; dx++)
                if (dx != 0 || dy != 0) m = mine_at(m, 4 + dx, 4 + dy);
        new_game(8, m);
        click(0, 4, 4, 1, F_REV, 8, 10);
        drain();

        // T3: flag toggling on a mine
        m = '0; m = mine_at(m, 3, 3);
        new_game(8, m);
        click(1, 3, 3, 1, F_FLG, 0, 2);
        drain();
        chk("t3_flags_used_set", int'(flags_used), 1);
        click(0, 3, 3, 1, F_IGN, 0, 2);
        drain();
        chk("t3_no_game_over", int'(game_over), 0);
        click(1, 3, 3, 1, 0, 0, 2);
        drain();
        chk("t3_flags_used_clr", int'(flags_used), 0);

        // T4: explode, then everything ignored until clear
        m = mine_at(m, 5, 5);
        new_game(8, m);
        click(0, 5, 5, 1, F_EXP, 0, 2);
        drain();
        chk("t4_game_over", int'(game_over), 1);
        click(0, 0, 0, 1, F_IGN, 0, 2);
        drain();
        new_game(8, m);
        chk("t4_game_over_clr", int'(game_over), 0);

        // T5: 10x10 board, out-of-range and right/bottom edge without wrap
        m = '0; m = mine_at(m, 8, 8); m = mine_at(m, 10, 9); m = mine_at(m, 9, 10);
        new_game(10, m);
        click(0, 10, 2, 1, F_IGN, 0, 2);
        click(0, 9, 9, 1, F_REV, 1, 10);
        click(1, 3, 10, 1, F_IGN, 0, 2);
        drain();
        chk("t5_flags_used", int'(flags_used), 0);

        // T6a: clear mid-scan drops the op; cell stays unrevealed
        new_game(8, '0);
        click(0, 1, 1, 0, 0, 0, 0);
        repeat (3) @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        chk("t6_ready_after_clear", int'(bus.req_ready), 1);
        repeat (15) @(negedge clk);
        click(0, 1, 1, 1, F_REV, 0, 10);
        drain();

        // T6b: reset mid-scan wipes flags and emits nothing
        click(1, 2, 2, 1, F_FLG, 0, 2);
        drain();
        chk("t6_flag_before_rst", int'(flags_used), 1);
        click(0, 6, 6, 0, 0, 0, 0);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("t6_rst_req_ready", int'(bus.req_ready), 1);
        chk("t6_rst_res_valid", int'(bus.res_valid), 0);
        chk("t6_rst_flags_used", int'(flags_used), 0);
        chk("t6_rst_game_over", int'(game_over), 0);
        rst = 1'b0;
        repeat (15) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

`default_nettype wire
